// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the second-read-port arbiter and its in-flight tracker.
package mem_arb_pkg;

  localparam int unsigned AW_DEF  = 15;
  localparam int unsigned DW_DEF  = 16;
  localparam int unsigned LAT_DEF = 2;

  localparam logic TAG_FETCH = 1'b0;
  localparam logic TAG_LOAD  = 1'b1;

  typedef struct packed {
    logic              vld;
    logic              tag;
    logic [AW_DEF-1:0] addr;
    logic              byp;
    logic [DW_DEF-1:0] bdata;
  } slot_t;

  // A later matching store overwrites an earlier captured one.
  function automatic slot_t slot_snoop(slot_t s, logic wen, logic [AW_DEF-1:0] waddr,
                                       logic [DW_DEF-1:0] wdata);
    slot_t r;
    r = s;
    if (s.vld && wen && (waddr == s.addr)) begin
      r.byp   = 1'b1;
      r.bdata = wdata;
    end
    return r;
  endfunction

endpackage

// File: rtl/rd_port_arbiter_if.sv
// Requester, store-snoop and memory read-port signals of the read-port arbiter.
interface rd_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
);
  logic          f_req;
  logic [AW-1:0] f_addr;
  logic          f_gnt;
  logic          f_rvalid;
  logic [DW-1:0] f_rdata;
  logic          l_req;
  logic [AW-1:0] l_addr;
  logic          l_gnt;
  logic          l_rvalid;
  logic [DW-1:0] l_rdata;
  logic          flush;
  logic          wen;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  f_req, f_addr, l_req, l_addr, flush, wen, waddr, wdata, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, mem_raddr, busy
  );

  modport master (
    output f_req, f_addr, l_req, l_addr, flush, wen, waddr, wdata, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, l_gnt, l_rvalid, l_rdata, mem_raddr, busy
  );

endinterface

// File: rtl/rd_inflight_pipe.sv
// LAT-deep shift register of in-flight reads with store snooping and flush kill.
module rd_inflight_pipe
  import mem_arb_pkg::*;
#(
  parameter int unsigned Lat = LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              gnt_vld_i,
  input  logic              gnt_tag_i,
  input  logic [AW_DEF-1:0] gnt_addr_i,
  input  logic              flush_i,
  input  logic              wen_i,
  input  logic [AW_DEF-1:0] waddr_i,
  input  logic [DW_DEF-1:0] wdata_i,
  output logic              dlv_vld_o,
  output logic              dlv_tag_o,
  output logic              dlv_byp_o,
  output logic [DW_DEF-1:0] dlv_bdata_o,
  output logic              busy_o
);

  // Index k holds slot k+1; index Lat-1 is the delivering slot.
  slot_t [Lat-1:0] slot_q, slot_d;
  slot_t           new_entry;
  slot_t           dlv;

  always_comb begin
    new_entry       = '0;
    new_entry.vld   = gnt_vld_i;
    new_entry.tag   = gnt_tag_i;
    new_entry.addr  = gnt_addr_i;
    slot_d          = '0;
    // A store in the grant cycle already counts for the new entry.
    slot_d[0]       = slot_snoop(new_entry, wen_i, waddr_i, wdata_i);
    for (int unsigned k = 1; k < Lat; k++) begin
      slot_d[k] = slot_snoop(slot_q[k-1], wen_i, waddr_i, wdata_i);
      if (flush_i && (slot_q[k-1].tag == TAG_FETCH)) begin
        slot_d[k].vld = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  always_comb begin
    dlv         = slot_q[Lat-1];
    dlv_vld_o   = dlv.vld && !(flush_i && (dlv.tag == TAG_FETCH));
    dlv_tag_o   = dlv.tag;
    dlv_byp_o   = dlv.byp;
    dlv_bdata_o = dlv.bdata;
    busy_o      = 1'b0;
    for (int unsigned k = 0; k < Lat; k++) begin
      busy_o = busy_o | slot_q[k].vld;
    end
  end

endmodule

// File: rtl/rd_port_arbiter.sv
// Arbitrates fetch and load onto the memory's second read port and routes the responses.
// AW/DW must equal the package slot widths; LAT is legal from 1 to 4.
module rd_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned LAT        = LAT_DEF,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic              clk,
  input logic              rst_n,
  rd_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 2);

  logic [CntW-1:0] starve_q, starve_d;
  logic [AW-1:0]   raddr_q, raddr_d;
  logic            starving;
  logic            fetch_ok;
  logic            f_gnt, l_gnt;
  logic            gnt_vld, gnt_tag;
  logic [AW-1:0]   gnt_addr;
  logic            dlv_vld, dlv_tag, dlv_byp;
  logic [DW-1:0]   dlv_bdata;
  logic [DW-1:0]   rsp_data;
  logic            busy;

  // Grants are gated by reset so nothing is accepted while the tracker is held clear.
  always_comb begin
    starving = (starve_q == CntW'(STARVE_MAX));
    fetch_ok = rst_n && bus.f_req && !bus.flush;
    f_gnt    = fetch_ok && (starving || !bus.l_req);
    l_gnt    = rst_n && bus.l_req && !f_gnt;
    gnt_vld  = f_gnt || l_gnt;
    gnt_tag  = f_gnt ? TAG_FETCH : TAG_LOAD;
    gnt_addr = f_gnt ? bus.f_addr : bus.l_addr;
    raddr_d  = gnt_vld ? gnt_addr : raddr_q;
  end

  always_comb begin
    starve_d = starve_q;
    if (!bus.f_req || bus.flush || f_gnt) begin
      starve_d = '0;
    end else if (!starving) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      raddr_q  <= '0;
    end else begin
      starve_q <= starve_d;
      raddr_q  <= raddr_d;
    end
  end

  rd_inflight_pipe #(
    .Lat (LAT)
  ) u_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .gnt_vld_i   (gnt_vld),
    .gnt_tag_i   (gnt_tag),
    .gnt_addr_i  (gnt_addr),
    .flush_i     (bus.flush),
    .wen_i       (bus.wen),
    .waddr_i     (bus.waddr),
    .wdata_i     (bus.wdata),
    .dlv_vld_o   (dlv_vld),
    .dlv_tag_o   (dlv_tag),
    .dlv_byp_o   (dlv_byp),
    .dlv_bdata_o (dlv_bdata),
    .busy_o      (busy)
  );

  always_comb begin
    rsp_data      = dlv_byp ? dlv_bdata : bus.mem_rdata;
    bus.f_gnt     = f_gnt;
    bus.l_gnt     = l_gnt;
    bus.mem_raddr = raddr_d;
    bus.busy      = busy;
    bus.f_rvalid  = dlv_vld && (dlv_tag == TAG_FETCH);
    bus.l_rvalid  = dlv_vld && (dlv_tag == TAG_LOAD);
    bus.f_rdata   = bus.f_rvalid ? rsp_data : '0;
    bus.l_rdata   = bus.l_rvalid ? rsp_data : '0;
  end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Randomised and directed bench for rd_port_arbiter against a transaction-list reference model.
module tb_rd_port_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW  = 15;
  localparam int unsigned DW  = 16;
  localparam int          LAT = 2;
  localparam int          SM  = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  rd_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  rd_port_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .LAT        (LAT),
    .STARVE_MAX (SM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One accepted read: who asked, where, when, and any store captured while in flight.
  typedef struct {
    bit            is_load;
    logic [AW-1:0] addr;
    int            g;
    bit            byp;
    logic [DW-1:0] bdata;
    bit            alive;
  } rd_t;

  rd_t           q[$];
  int            cyc = 0;
  int            starve = 0;
  logic [AW-1:0] last_addr = '0;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Drives one cycle of inputs, checks all outputs against the model, advances to next negedge.
  task automatic step(input bit fr, input logic [AW-1:0] fa, input bit lr,
                      input logic [AW-1:0] la, input bit fl, input bit we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [DW-1:0] rd, output bit efg, output bit elg);
    bit            ebusy, efv, elv;
    logic [DW-1:0] efd, eld, d;
    logic [AW-1:0] eraddr;
    rd_t           e;
    rd_t           keep[$];
    int            age;
    bus.f_req = fr;  bus.f_addr = fa;  bus.l_req = lr;  bus.l_addr = la;
    bus.flush = fl;  bus.wen = we;     bus.waddr = wa;  bus.wdata = wd;
    bus.mem_rdata = rd;
    #1;
    efg = fr && !fl && (starve == SM || !lr);
    elg = lr && !efg;
    ebusy = 0; efv = 0; elv = 0; efd = '0; eld = '0;
    foreach (q[i]) begin
      age = cyc - q[i].g;
      if (q[i].alive && age >= 1 && age <= LAT) ebusy = 1;
      if (q[i].alive && age == LAT && !(fl && !q[i].is_load)) begin
        d = q[i].byp ? q[i].bdata : rd;
        if (q[i].is_load) begin elv = 1; eld = d; end
        else begin efv = 1; efd = d; end
      end
    end
    eraddr = efg ? fa : (elg ? la : last_addr);
    check_val("f_gnt", 32'(bus.f_gnt), 32'(efg));
    check_val("l_gnt", 32'(bus.l_gnt), 32'(elg));
    check_val("f_rvalid", 32'(bus.f_rvalid), 32'(efv));
    check_val("f_rdata", 32'(bus.f_rdata), 32'(efd));
    check_val("l_rvalid", 32'(bus.l_rvalid), 32'(elv));
    check_val("l_rdata", 32'(bus.l_rdata), 32'(eld));
    check_val("mem_raddr", 32'(bus.mem_raddr), 32'(eraddr));
    check_val("busy", 32'(bus.busy), 32'(ebusy));
    if (efg || elg) begin
      e.is_load = elg; e.addr = efg ? fa : la; e.g = cyc;
      e.byp = 0; e.bdata = '0; e.alive = 1;
      q.push_back(e);
      last_addr = e.addr;
    end
    foreach (q[i]) begin
      age = cyc - q[i].g;
      if (q[i].alive && age <= LAT - 1 && we && wa == q[i].addr) begin
        q[i].byp = 1; q[i].bdata = wd;
      end
      if (fl && !q[i].is_load && age >= 1) q[i].alive = 0;
    end
    if (!fr || fl || efg) starve = 0;
    else if (starve < SM) starve++;
    cyc++;
    foreach (q[i]) if (cyc - q[i].g <= LAT) keep.push_back(q[i]);
    q = keep;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic [DW-1:0] rd);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, '0, 0, '0, 0, 0, '0, '0, rd, a, b);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_f_gnt"}, 32'(bus.f_gnt), 32'd0);
    check_val({tag, "_l_gnt"}, 32'(bus.l_gnt), 32'd0);
    check_val({tag, "_f_rvalid"}, 32'(bus.f_rvalid), 32'd0);
    check_val({tag, "_l_rvalid"}, 32'(bus.l_rvalid), 32'd0);
    check_val({tag, "_f_rdata"}, 32'(bus.f_rdata), 32'd0);
    check_val({tag, "_l_rdata"}, 32'(bus.l_rdata), 32'd0);
    check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
    check_val({tag, "_mem_raddr"}, 32'(bus.mem_raddr), 32'd0);
  endtask

  // Asserts reset asynchronously mid-cycle with requests pending, then releases it.
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.f_req = 1; bus.f_addr = 15'h0033; bus.l_req = 1; bus.l_addr = 15'h0044;
    bus.mem_rdata = 16'hA5A5;
    #1;
    check_reset_outputs("rst");
    q.delete();
    starve = 0;
    last_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  bit            fg, lg;
  bit            f_pend, l_pend;
  logic [AW-1:0] f_a, l_a;
  bit            fl;

  initial begin
    bus.f_req = 0; bus.f_addr = '0; bus.l_req = 0; bus.l_addr = '0; bus.flush = 0;
    bus.wen = 0; bus.waddr = '0; bus.wdata = '0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("init");
    rst_n = 1'b1;
    idle(1, '0);

    // Single load with memory data
    step(0, '0, 1, 15'h0010, 0, 0, '0, '0, '0, fg, lg);
    idle(1, 16'h1111);
    idle(1, 16'hBEEF);
    idle(1, '0);

    // Both requesting for 8 cycles: fetch wins every fourth cycle
    for (int i = 0; i < 8; i++) step(1, 15'h0100, 1, 15'h0200, 0, 0, '0, '0, 16'(i), fg, lg);
    idle(3, 16'h7777);

    // Store to the same address while the load is in flight
    step(0, '0, 1, 15'h0020, 0, 0, '0, '0, '0, fg, lg);
    step(0, '0, 0, '0, 0, 1, 15'h0020, 16'h1234, '0, fg, lg);
    idle(2, 16'h0000);

    // Store and grant to the same address in one cycle
    step(0, '0, 1, 15'h0021, 0, 1, 15'h0021, 16'h5678, '0, fg, lg);
    idle(3, 16'h9999);

    // Fetch then load under flush
    step(1, 15'h0030, 0, '0, 0, 0, '0, '0, '0, fg, lg);
    step(0, '0, 1, 15'h0031, 1, 0, '0, '0, '0, fg, lg);
    idle(4, 16'h4242);

    // Fetch blocked by flush for two cycles
    step(1, 15'h0040, 0, '0, 1, 0, '0, '0, '0, fg, lg);
    step(1, 15'h0040, 0, '0, 1, 0, '0, '0, '0, fg, lg);
    step(1, 15'h0040, 0, '0, 0, 0, '0, '0, '0, fg, lg);
    idle(3, 16'h0F0F);

    // Reset in the cycle after a grant
    step(0, '0, 1, 15'h0050, 0, 0, '0, '0, '0, fg, lg);
    apply_reset();
    idle(4, 16'hDEAD);

    // Randomised traffic
    f_pend = 0; l_pend = 0; f_a = '0; l_a = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!f_pend && ($urandom_range(0, 1) == 1)) begin
        f_pend = 1; f_a = AW'($urandom_range(0, 7));
      end
      if (!l_pend && ($urandom_range(0, 4) < 3)) begin
        l_pend = 1; l_a = AW'($urandom_range(0, 7));
      end
      fl = ($urandom_range(0, 7) == 0);
      step(f_pend, f_a, l_pend, l_a, fl, ($urandom_range(0, 1) == 1),
           AW'($urandom_range(0, 7)), DW'($urandom), DW'($urandom), fg, lg);
      if (fg) f_pend = 0;
      if (lg) l_pend = 0;
      if (fl && ($urandom_range(0, 1) == 1)) f_pend = 0;
      if ((i % 997) == 500) begin
        apply_reset();
        f_pend = 0; l_pend = 0;
      end
    end
    idle(LAT + 2, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
